// File: rtl/key_direction_controller_if.sv
// Handshake bundle between the scancode source / game core and the direction controller.
// master: keyboard receiver plus game core side; slave: the controller itself.
interface key_direction_controller_if;
  logic       code_valid;
  logic [7:0] code;
  logic       move_ack;
  logic       move_req;
  logic [1:0] req_dir;
  logic       held;
  logic [1:0] held_dir;
  logic       prefix_err;

  modport master (
    output code_valid, code, move_ack,
    input  move_req, req_dir, held, held_dir, prefix_err
  );

  modport slave (
    input  code_valid, code, move_ack,
    output move_req, req_dir, held, held_dir, prefix_err
  );
endinterface

// File: rtl/key_direction_controller.sv
// Turns PS/2 set-2 make/break/E0 sequences into a held direction plus move requests,
// with auto-repeat (initial delay, then fixed rate) and a req/ack handshake to the game core.
module key_direction_controller #(
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter int PREFIX_TIMEOUT = 250000
) (
  input logic                           clk,
  input logic                           rst,
  key_direction_controller_if.slave     kdc_if
);

  localparam int MaxA     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MaxParam = (MaxA > PREFIX_TIMEOUT) ? MaxA : PREFIX_TIMEOUT;
  localparam int TW       = $clog2(MaxParam) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BREAK,
    S_EXT_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [TW-1:0]   rep_cnt_q, rep_cnt_d;
  logic            held_q, held_d;
  logic [1:0]      held_dir_q, held_dir_d;
  logic            move_req_q, move_req_d;
  logic [1:0]      req_dir_q, req_dir_d;
  logic            prefix_err_q, prefix_err_d;

  logic            make_evt, brk_evt;
  logic            code_is_dir;
  logic [1:0]      code_dir;
  logic            new_make, held_brk, rep_expire, rep_evt;

  always_comb begin
    code_is_dir = 1'b1;
    code_dir    = 2'b00;
    case (kdc_if.code)
      8'h75:   code_dir = 2'b00;
      8'h72:   code_dir = 2'b01;
      8'h6B:   code_dir = 2'b10;
      8'h74:   code_dir = 2'b11;
      default: code_is_dir = 1'b0;
    endcase
  end

  // Prefix parser: classifies each byte as make, break or prefix and polices prefix timing.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    prefix_err_d = 1'b0;
    make_evt     = 1'b0;
    brk_evt      = 1'b0;
    if (kdc_if.code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (kdc_if.code == 8'hE0) begin
            state_d   = S_EXT;
            pre_cnt_d = TW'(PREFIX_TIMEOUT);
          end else if (kdc_if.code == 8'hF0) begin
            state_d   = S_BREAK;
            pre_cnt_d = TW'(PREFIX_TIMEOUT);
          end else begin
            make_evt = 1'b1;
          end
        end
        S_EXT: begin
          if (kdc_if.code == 8'hF0) begin
            state_d   = S_EXT_BREAK;
            pre_cnt_d = TW'(PREFIX_TIMEOUT);
          end else if (kdc_if.code == 8'hE0) begin
            prefix_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            make_evt = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BREAK, S_EXT_BREAK: begin
          if (kdc_if.code == 8'hE0 || kdc_if.code == 8'hF0) begin
            prefix_err_d = 1'b1;
          end else begin
            brk_evt = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (pre_cnt_q <= TW'(1)) begin
        prefix_err_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        pre_cnt_d = pre_cnt_q - TW'(1);
      end
    end
  end

  // Held-key tracking, repeat timer and request handshake; a fresh make always beats a repeat.
  always_comb begin
    new_make   = make_evt && code_is_dir && (!held_q || code_dir != held_dir_q);
    held_brk   = brk_evt && code_is_dir && held_q && (code_dir == held_dir_q);
    rep_expire = held_q && (rep_cnt_q <= TW'(1));
    rep_evt    = rep_expire && !held_brk && !new_make;

    held_d     = held_q;
    held_dir_d = held_dir_q;
    req_dir_d  = req_dir_q;
    rep_cnt_d  = rep_cnt_q;
    move_req_d = move_req_q && !kdc_if.move_ack;

    if (held_q) begin
      rep_cnt_d = rep_expire ? TW'(REPEAT_RATE) : (rep_cnt_q - TW'(1));
    end

    if (new_make) begin
      held_d     = 1'b1;
      held_dir_d = code_dir;
      move_req_d = 1'b1;
      req_dir_d  = code_dir;
      rep_cnt_d  = TW'(REPEAT_DELAY);
    end else if (held_brk) begin
      held_d    = 1'b0;
      rep_cnt_d = '0;
    end

    if (rep_evt && (!move_req_q || kdc_if.move_ack)) begin
      move_req_d = 1'b1;
      req_dir_d  = held_dir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      held_q       <= 1'b0;
      held_dir_q   <= 2'b00;
      move_req_q   <= 1'b0;
      req_dir_q    <= 2'b00;
      prefix_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      held_q       <= held_d;
      held_dir_q   <= held_dir_d;
      move_req_q   <= move_req_d;
      req_dir_q    <= req_dir_d;
      prefix_err_q <= prefix_err_d;
    end
  end

  assign kdc_if.move_req   = move_req_q;
  assign kdc_if.req_dir    = req_dir_q;
  assign kdc_if.held       = held_q;
  assign kdc_if.held_dir   = held_dir_q;
  assign kdc_if.prefix_err = prefix_err_q;

endmodule

// File: tb/tb_key_direction_controller.sv
// Scoreboard bench for key_direction_controller: expected requests (direction and cycle)
// are queued as stimulus is driven and matched against every new request the DUT raises.
module tb_key_direction_controller;

  localparam int RD = 20;
  localparam int RR = 5;
  localparam int PT = 8;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   errCount = 0;
  int   lastErrCyc = -1;
  logic prevReq = 1'b0;
  logic [1:0] prevDir = 2'b00;
  logic autoAck = 1'b0;

  key_direction_controller_if kif ();

  key_direction_controller #(
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR),
    .PREFIX_TIMEOUT(PT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .kdc_if(kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each new request (rise, or direction change while pending) consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (kif.move_req === 1'b1 && (prevReq !== 1'b1 || kif.req_dir !== prevDir)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_req: got dir=%b at cyc=%0d, required no request", kif.req_dir, cyc);
      end else begin
        e = sb.pop_front();
        if (kif.req_dir !== e.dir || cyc !== e.cyc) begin
          bad++;
          $display("[TB] FAIL req_match: got dir=%b cyc=%0d, required dir=%b cyc=%0d",
                   kif.req_dir, cyc, e.dir, e.cyc);
        end
      end
    end
    if (kif.prefix_err === 1'b1) begin
      errCount++;
      lastErrCyc = cyc;
    end
    prevReq = kif.move_req;
    prevDir = kif.req_dir;
    kif.move_ack = autoAck && (kif.move_req === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int cap);
    kif.code_valid = 1'b1;
    kif.code       = b;
    cap            = cyc + 1;
    @(posedge clk);
    #1;
    kif.code_valid = 1'b0;
    kif.code       = 8'h00;
  endtask

  task automatic expect_req(input logic [1:0] dir, input int c);
    exp_t e;
    e.dir = dir;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_missing_req: got %0d outstanding, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    rst            = 1'b1;
    autoAck        = 1'b0;
    kif.code_valid = 1'b0;
    kif.code       = 8'h00;
    kif.move_ack   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      kif.code_valid = 1'($urandom_range(0, 1));
      kif.code       = 8'($urandom_range(0, 255));
      @(negedge clk);
      outs = {kif.move_req, kif.req_dir, kif.held, kif.held_dir, kif.prefix_err};
      total++;
      if (outs !== 7'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: got %b, required 0000000", outs);
      end
    end
    @(posedge clk);
    #1;
    kif.code_valid = 1'b0;
    rst            = 1'b0;
    step(2);
    outs = {kif.move_req, kif.req_dir, kif.held, kif.held_dir, kif.prefix_err};
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got %b, required 0000000", outs);
    end
  endtask

  task automatic test_repeat();
    int c0, c;
    autoAck = 1'b1;
    send_byte(8'h72, c0);
    expect_req(2'b01, c0);
    for (int t = c0 + RD; t < c0 + 38; t += RR) expect_req(2'b01, t);
    total++;
    if (kif.held !== 1'b1 || kif.held_dir !== 2'b01) begin
      bad++;
      $display("[TB] FAIL repeat_held: got held=%b dir=%b, required held=1 dir=01", kif.held, kif.held_dir);
    end
    step(36);
    send_byte(8'hF0, c);
    send_byte(8'h72, c);
    total++;
    if (kif.held !== 1'b0) begin
      bad++;
      $display("[TB] FAIL repeat_release: got held=%b, required 0", kif.held);
    end
    step(30);
    check_drained("repeat");
  endtask

  task automatic test_coalesce();
    int c1, c2, c;
    autoAck = 1'b0;
    send_byte(8'hE0, c);
    send_byte(8'h6B, c1);
    expect_req(2'b10, c1);
    total++;
    if (kif.move_req !== 1'b1 || kif.req_dir !== 2'b10) begin
      bad++;
      $display("[TB] FAIL coalesce_first: got req=%b dir=%b, required req=1 dir=10", kif.move_req, kif.req_dir);
    end
    step(3);
    send_byte(8'hE0, c);
    send_byte(8'h74, c2);
    expect_req(2'b11, c2);
    step(2);
    total++;
    if (kif.move_req !== 1'b1 || kif.req_dir !== 2'b11 || kif.held_dir !== 2'b11) begin
      bad++;
      $display("[TB] FAIL coalesce_second: got req=%b dir=%b held_dir=%b, required 1/11/11",
               kif.move_req, kif.req_dir, kif.held_dir);
    end
    autoAck = 1'b1;
    step(3);
    total++;
    if (kif.move_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coalesce_ack: got req=%b, required 0", kif.move_req);
    end
    send_byte(8'hE0, c);
    send_byte(8'hF0, c);
    send_byte(8'h74, c);
    total++;
    if (kif.held !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coalesce_release: got held=%b, required 0", kif.held);
    end
    step(25);
    check_drained("coalesce");
  endtask

  task automatic test_unacked_repeats();
    int c3, c;
    autoAck = 1'b0;
    send_byte(8'h75, c3);
    expect_req(2'b00, c3);
    step(32);
    total++;
    if (kif.move_req !== 1'b1 || kif.req_dir !== 2'b00) begin
      bad++;
      $display("[TB] FAIL unacked_pending: got req=%b dir=%b, required req=1 dir=00", kif.move_req, kif.req_dir);
    end
    autoAck = 1'b1;
    expect_req(2'b00, c3 + RD + 3 * RR);
    step(2);
    total++;
    if (kif.move_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL unacked_cleared: got req=%b, required 0", kif.move_req);
    end
    step(2);
    send_byte(8'hF0, c);
    send_byte(8'h75, c);
    step(25);
    check_drained("unacked");
  endtask

  task automatic test_prefix_timeout();
    int p, m, c, e0;
    autoAck = 1'b1;
    e0 = errCount;
    send_byte(8'hF0, p);
    step(15);
    total++;
    if (errCount - e0 !== 1) begin
      bad++;
      $display("[TB] FAIL timeout_pulses: got %0d, required 1", errCount - e0);
    end
    total++;
    if (lastErrCyc !== p + PT) begin
      bad++;
      $display("[TB] FAIL timeout_cycle: got %0d, required %0d", lastErrCyc, p + PT);
    end
    send_byte(8'h72, m);
    expect_req(2'b01, m);
    step(2);
    send_byte(8'hF0, c);
    send_byte(8'h72, c);
    step(25);
    check_drained("timeout");
  endtask

  task automatic test_misordered();
    int e, m, c, e0;
    autoAck = 1'b1;
    e0 = errCount;
    send_byte(8'hF0, c);
    send_byte(8'hE0, e);
    step(3);
    total++;
    if (errCount - e0 !== 1 || lastErrCyc !== e) begin
      bad++;
      $display("[TB] FAIL misorder_err: got count=%0d cyc=%0d, required count=1 cyc=%0d",
               errCount - e0, lastErrCyc, e);
    end
    send_byte(8'h72, m);
    expect_req(2'b01, m);
    step(2);
    send_byte(8'hF0, c);
    send_byte(8'h6B, c);
    total++;
    if (kif.held !== 1'b1 || kif.held_dir !== 2'b01) begin
      bad++;
      $display("[TB] FAIL foreign_break: got held=%b dir=%b, required held=1 dir=01", kif.held, kif.held_dir);
    end
    send_byte(8'hF0, c);
    send_byte(8'h72, c);
    step(25);
    check_drained("misorder");
  endtask

  task automatic test_reset_mid();
    logic [6:0] outs;
    int c, m;
    autoAck = 1'b0;
    send_byte(8'h6B, c);
    expect_req(2'b10, c);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    outs = {kif.move_req, kif.req_dir, kif.held, kif.held_dir, kif.prefix_err};
    total++;
    if (outs !== 7'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs: got %b, required 0000000", outs);
    end
    send_byte(8'hF0, c);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    send_byte(8'h72, m);
    expect_req(2'b01, m);
    autoAck = 1'b1;
    step(2);
    send_byte(8'hF0, c);
    send_byte(8'h72, c);
    step(5);
    check_drained("mid_reset");
  endtask

  initial begin
    test_reset();
    test_repeat();
    test_coalesce();
    test_unacked_repeats();
    test_prefix_timeout();
    test_misordered();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
